// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: ALU and RV32M op codes, mul/div FSM states
// and the result fix-up helpers.
package execute_stage_pkg;

  localparam int XLEN     = 32;
  localparam int MD_CNT_W = 5;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

  // Signs were stripped on accept; put them back and pick the half the op wants.
  function automatic logic [XLEN-1:0] md_fixup(input logic [2:0] op, input logic [2*XLEN-1:0] acc,
                                               input logic neg_lo, input logic neg_rem);
    logic [2*XLEN-1:0] p;
    p = neg_lo ? (~acc + (2*XLEN)'(1)) : acc;
    case (op)
      MD_MUL:                       return p[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: return p[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              return negate(acc[XLEN-1:0], neg_lo);
      default:                      return negate(acc[2*XLEN-1:XLEN], neg_rem);
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_muldiv.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide over a shared
// 64-bit accumulator, with divide-by-zero and overflow resolved without iterating.
module execute_stage_muldiv
  import execute_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  md_state_t           r_state;
  logic [MD_CNT_W-1:0] r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic [2:0]          r_op;
  logic                r_neg_lo;
  logic                r_neg_rem;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div;
  logic                w_sgn_a;
  logic                w_sgn_b;
  logic                w_div0;
  logic                w_ovf;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic [XLEN-1:0]     w_special;
  logic [XLEN:0]       w_mul_sum;
  logic [XLEN:0]       w_trial;
  logic [2*XLEN-1:0]   w_step;

  // Accept-time decode: operand magnitudes, signs and the two divide short-cuts
  always_comb begin
    w_is_div = i_op[2];
    w_sgn_a  = i_a[XLEN-1] & (i_op != MD_MULHU) & (i_op != MD_DIVU) & (i_op != MD_REMU);
    w_sgn_b  = i_b[XLEN-1] & ((i_op == MD_MUL) | (i_op == MD_MULH) |
                              (i_op == MD_DIV) | (i_op == MD_REM));
    w_abs_a  = negate(i_a, w_sgn_a);
    w_abs_b  = negate(i_b, w_sgn_b);
    w_div0   = w_is_div & (i_b == 32'h0000_0000);
    w_ovf    = w_is_div & ~i_op[0] & (i_a == 32'h8000_0000) & (i_b == 32'hFFFF_FFFF);
    if (w_div0) begin
      w_special = i_op[1] ? i_a : 32'hFFFF_FFFF;
    end else if (w_ovf) begin
      w_special = i_op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      w_special = 32'h0000_0000;
    end
  end

  // One radix-2 iteration of the latched operation
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    w_trial   = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
    if (r_op[2]) begin
      if (w_trial[XLEN]) begin
        w_step = {r_acc[2*XLEN-2:0], 1'b0};
      end else begin
        w_step = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      w_step = {w_mul_sum, r_acc[XLEN-1:1]};
    end
  end

  // Sequencer: IDLE accepts, BUSY iterates 32 times, DONE presents the result for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MD_IDLE;
      r_cnt     <= {MD_CNT_W{1'b0}};
      r_acc     <= {(2*XLEN){1'b0}};
      r_opnd    <= {XLEN{1'b0}};
      r_op      <= 3'd0;
      r_neg_lo  <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= {XLEN{1'b0}};
    end else if (i_kill) begin
      r_state <= MD_IDLE;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_op      <= i_op;
            r_cnt     <= {MD_CNT_W{1'b0}};
            r_neg_lo  <= w_sgn_a ^ w_sgn_b;
            r_neg_rem <= w_sgn_a;
            r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_opnd    <= w_is_div ? w_abs_b : w_abs_a;
            if (w_div0 | w_ovf) begin
              r_result <= w_special;
              r_state  <= MD_DONE;
            end else begin
              r_state  <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + MD_CNT_W'(1);
          if (r_cnt == {MD_CNT_W{1'b1}}) begin
            r_result <= md_fixup(r_op, w_step, r_neg_lo, r_neg_rem);
            r_state  <= MD_DONE;
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign o_busy   = (r_state == MD_BUSY);
  assign o_done   = (r_state == MD_DONE);
  assign o_result = r_result;

endmodule

// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU, iterative mul/div unit, result mux and the EX/MEM register.
// Holds upstream with stallE while a mul/div is in flight and feeds bubbles to MEM meanwhile.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flushE,
  input  logic [3:0]      ALUCtrlE,
  input  logic            mdEnE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [XLEN-1:0] r2E,
  input  logic [4:0]      rdE,
  input  logic [2:0]      strCtrlE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            MemtoRegE,
  output logic            stallE,
  output logic [XLEN-1:0] ALUoutM,
  output logic [XLEN-1:0] r2M,
  output logic [4:0]      rdM,
  output logic [2:0]      strCtrlM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            MemtoRegM
);

  logic            w_md_busy;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_result;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_res;
  logic [4:0]      w_shamt;

  execute_stage_muldiv u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (mdEnE),
    .i_op     (funct3E),
    .i_a      (SrcAE),
    .i_b      (SrcBE),
    .i_kill   (flushE),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // An op being accepted in IDLE stalls too, so upstream holds it for the whole run
  assign stallE = ~flushE & (w_md_busy | (mdEnE & ~w_md_done));

  // Single-cycle ALU
  always_comb begin
    w_shamt = SrcBE[4:0];
    case (ALUCtrlE)
      ALU_ADD:   w_alu = SrcAE + SrcBE;
      ALU_SUB:   w_alu = SrcAE - SrcBE;
      ALU_AND:   w_alu = SrcAE & SrcBE;
      ALU_OR:    w_alu = SrcAE | SrcBE;
      ALU_XOR:   w_alu = SrcAE ^ SrcBE;
      ALU_SLL:   w_alu = SrcAE << w_shamt;
      ALU_SRL:   w_alu = SrcAE >> w_shamt;
      ALU_SRA:   w_alu = $unsigned($signed(SrcAE) >>> w_shamt);
      ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
      ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (SrcAE < SrcBE)};
      ALU_PASSB: w_alu = SrcBE;
      default:   w_alu = {XLEN{1'b0}};
    endcase
    w_res = w_md_done ? w_md_result : w_alu;
  end

  // EX/MEM register; flush and stall both load a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUoutM   <= {XLEN{1'b0}};
      r2M       <= {XLEN{1'b0}};
      rdM       <= 5'd0;
      strCtrlM  <= 3'd0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
    end else if (flushE | stallE) begin
      ALUoutM   <= {XLEN{1'b0}};
      r2M       <= {XLEN{1'b0}};
      rdM       <= 5'd0;
      strCtrlM  <= 3'd0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
    end else begin
      ALUoutM   <= w_res;
      r2M       <= r2E;
      rdM       <= rdE;
      strCtrlM  <= strCtrlE;
      RegWriteM <= RegWriteE;
      MemWriteM <= MemWriteE;
      MemtoRegM <= MemtoRegE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, random ops against an
// arithmetic reference model, and hand sequences for flush and mid-operation reset.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flushE = 1'b0;
  logic [3:0]  ALUCtrlE = 4'd0;
  logic        mdEnE = 1'b0;
  logic [2:0]  funct3E = 3'd0;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic [31:0] r2E = 32'd0;
  logic [4:0]  rdE = 5'd0;
  logic [2:0]  strCtrlE = 3'd0;
  logic        RegWriteE = 1'b0;
  logic        MemWriteE = 1'b0;
  logic        MemtoRegE = 1'b0;
  logic        stallE;
  logic [31:0] ALUoutM;
  logic [31:0] r2M;
  logic [4:0]  rdM;
  logic [2:0]  strCtrlM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        MemtoRegM;

  int n_cmp = 0;
  int n_fail = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .flushE(flushE), .ALUCtrlE(ALUCtrlE), .mdEnE(mdEnE),
    .funct3E(funct3E), .SrcAE(SrcAE), .SrcBE(SrcBE), .r2E(r2E), .rdE(rdE),
    .strCtrlE(strCtrlE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .stallE(stallE), .ALUoutM(ALUoutM), .r2M(r2M), .rdM(rdM), .strCtrlM(strCtrlM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          md;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return $unsigned($signed(a) >>> sh);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin if (b == 32'd0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 32'd0) return 32'hFFFFFFFF; up = ua / ub; return up[31:0]; end
      3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 32'd0) return a; up = ua % ub; return up[31:0]; end
    endcase
  endfunction

  function automatic int ref_stall(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 >= 3'd4 && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Present one op and clock until the EX/MEM register takes its result
  task automatic exec(input bit md, input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                      output int stalls, output bit bub_ok, output bit to);
    logic st;
    mdEnE = md;
    if (md) begin
      funct3E  = code[2:0];
      ALUCtrlE = 4'($urandom);
    end else begin
      ALUCtrlE = code;
      funct3E  = 3'($urandom);
    end
    SrcAE = a;
    SrcBE = b;
    stalls = 0;
    bub_ok = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1 st = stallE;
      @(posedge clk);
      #1;
      if (st) begin
        stalls++;
        if ({ALUoutM, r2M, rdM, strCtrlM, RegWriteM, MemWriteM, MemtoRegM} !== 75'd0) bub_ok = 1'b0;
      end else begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input bit md, input logic [3:0] code, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int stalls;
    bit bub_ok, to;
    logic [42:0] ctl;
    rdE = 5'($urandom);
    strCtrlE = 3'($urandom);
    r2E = $urandom;
    RegWriteE = 1'($urandom);
    MemWriteE = 1'($urandom);
    MemtoRegE = 1'($urandom);
    ctl = {r2E, strCtrlE, rdE, RegWriteE, MemWriteE, MemtoRegE};
    exec(md, code, a, b, stalls, bub_ok, to);
    chk({tag, "/in_budget"}, 64'(to), 64'd0);
    chk({tag, "/result"}, 64'(ALUoutM), 64'(exp));
    chk({tag, "/stall_cycles"}, 64'(stalls), 64'(exp_stall));
    chk({tag, "/bubbles"}, 64'(bub_ok), 64'd1);
    chk({tag, "/ctrl"}, 64'({r2M, strCtrlM, rdM, RegWriteM, MemWriteM, MemtoRegM}), 64'(ctl));
  endtask

  initial begin
    bit          md;
    logic [3:0]  code;
    logic [31:0] a, b, exp;
    int          stl, sel;

    tbl[0]  = '{1'b0, 4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 0};
    tbl[1]  = '{1'b0, 4'd7,  32'h80000000, 32'd4,        32'hF8000000, 0};
    tbl[2]  = '{1'b0, 4'd9,  32'd1,        32'd2,        32'd1,        0};
    tbl[3]  = '{1'b0, 4'd12, 32'h12345678, 32'h9ABCDEF0, 32'd0,        0};
    tbl[4]  = '{1'b0, 4'd5,  32'd1,        32'd33,       32'd2,        0};
    tbl[5]  = '{1'b1, 4'd0,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    tbl[6]  = '{1'b1, 4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    tbl[7]  = '{1'b1, 4'd4,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    tbl[8]  = '{1'b1, 4'd6,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    tbl[9]  = '{1'b1, 4'd5,  32'd100,      32'd7,        32'd14,       33};
    tbl[10] = '{1'b1, 4'd5,  32'd5,        32'd0,        32'hFFFFFFFF, 1};
    tbl[11] = '{1'b1, 4'd6,  32'd5,        32'd0,        32'd5,        1};
    tbl[12] = '{1'b1, 4'd4,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[13] = '{1'b1, 4'd6,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    tbl[14] = '{1'b1, 4'd1,  32'h80000000, 32'h80000000, 32'h40000000, 33};
    tbl[15] = '{1'b1, 4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};

    // Reset state
    #12;
    chk("reset/outputs", 64'({ALUoutM, rdM, strCtrlM, RegWriteM, MemWriteM, MemtoRegM}), 64'd0);
    chk("reset/r2M", 64'(r2M), 64'd0);
    chk("reset/stallE", 64'(stallE), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      run_check($sformatf("vec%0d", i), tbl[i].md, tbl[i].code, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].stall);
    end

    // Random ops, back to back, against the reference model
    for (int i = 0; i < 50; i++) begin
      md = 1'($urandom);
      code = md ? {1'b0, 3'($urandom)} : 4'($urandom);
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) begin
        a = 32'($urandom_range(0, 200)) ^ {32{1'($urandom)}};
        b = 32'($urandom_range(1, 20)) ^ {32{1'($urandom)}};
      end
      exp = md ? ref_md(code[2:0], a, b) : ref_alu(code, a, b);
      stl = md ? ref_stall(code[2:0], a, b) : 0;
      run_check($sformatf("rnd%0d", i), md, code, a, b, exp, stl);
    end

    // Flush on BUSY cycle 10, then an ADD that must complete in one cycle
    mdEnE = 1'b1; funct3E = 3'd0; SrcAE = 32'd1234; SrcBE = 32'd5678;
    RegWriteE = 1'b1; rdE = 5'd5;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("flush/stall_before", 64'(stallE), 64'd1);
    flushE = 1'b1;
    #1 chk("flush/stall_during", 64'(stallE), 64'd0);
    @(posedge clk);
    #1;
    chk("flush/bubble", 64'({RegWriteM, rdM, ALUoutM}), 64'd0);
    flushE = 1'b0; mdEnE = 1'b0; ALUCtrlE = 4'd0; SrcAE = 32'd1; SrcBE = 32'd1; rdE = 5'd9;
    #1 chk("flush/stall_after", 64'(stallE), 64'd0);
    @(posedge clk);
    #1;
    chk("flush/add_result", 64'(ALUoutM), 64'd2);
    chk("flush/add_ctrl", 64'({RegWriteM, rdM}), 64'({1'b1, 5'd9}));

    // Asynchronous clear of a live EX/MEM value
    rst_n = 1'b0;
    #1 chk("areset/outputs", 64'({ALUoutM, rdM, RegWriteM}), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset during BUSY, then a full-latency MUL
    mdEnE = 1'b1; funct3E = 3'd0; SrcAE = 32'd99; SrcBE = 32'd77; rdE = 5'd3; RegWriteE = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0; mdEnE = 1'b0; RegWriteE = 1'b0; rdE = 5'd0;
    #1;
    chk("busy_reset/outputs", 64'({ALUoutM, rdM, strCtrlM, RegWriteM, MemWriteM, MemtoRegM}), 64'd0);
    chk("busy_reset/stallE", 64'(stallE), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_check("post_reset_mul", 1'b1, 4'd0, 32'd3, 32'd4, 32'd12, 33);

    mdEnE = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
